// File: rtl/dc_pwm_drv.sv
// rtl/dc_pwm_drv.sv - edge-aligned H-bridge PWM driver with boundary-latched duty/direction and reversal dead time
module dc_pwm_drv #(
    parameter int CLK_FRE   = 50,
    parameter int PWM_FRE   = 20_000,
    parameter int DEAD_CLKS = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dc_duty,
    input  logic       dc_dir,
    input  logic       dc_en,
    output logic       pwm_a,
    output logic       pwm_b,
    output logic       period_start,
    output logic       dead_busy
);

    localparam int PERIOD = CLK_FRE * 1_000_000 / PWM_FRE;
    localparam int STEP   = PERIOD / 100;
    localparam int CW     = $clog2(PERIOD + 1);
    localparam int DW     = $clog2(DEAD_CLKS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DEAD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dead_cnt;
    logic [6:0]    duty_q;
    logic          dir_q;
    logic [11:0]   th;
    logic [6:0]    duty_clamp;
    logic          on;

    always_comb begin
        duty_clamp = (dc_duty > 8'd100) ? 7'd100 : dc_duty[6:0];
    end

    // Threshold follows the latched duty, so it only moves at a load.
    always_comb begin
        th = 12'(duty_q) * 12'(STEP);
        on = (32'(cnt) < 32'(th));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            dead_cnt     <= '0;
            duty_q       <= '0;
            dir_q        <= 1'b0;
            pwm_a        <= 1'b0;
            pwm_b        <= 1'b0;
            period_start <= 1'b0;
            dead_busy    <= 1'b0;
        end else begin
            // Outputs reflect the state/count of the previous cycle; dir_q is a
            // single bit, so at most one leg can ever be driven.
            pwm_a        <= (state == S_RUN) && on && !dir_q;
            pwm_b        <= (state == S_RUN) && on && dir_q;
            period_start <= (state == S_RUN) && (cnt == '0);
            dead_busy    <= (state == S_DEAD);

            if (!dc_en) begin
                state    <= S_IDLE;
                cnt      <= '0;
                dead_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state  <= S_RUN;
                        cnt    <= '0;
                        duty_q <= duty_clamp;
                        dir_q  <= dc_dir;
                    end
                    S_RUN: begin
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (dc_dir == dir_q) begin
                                duty_q <= duty_clamp;
                                dir_q  <= dc_dir;
                            end else begin
                                state    <= S_DEAD;
                                dead_cnt <= '0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DEAD: begin
                        if (dead_cnt == DEAD_LAST) begin
                            state  <= S_RUN;
                            cnt    <= '0;
                            duty_q <= duty_clamp;
                            dir_q  <= dc_dir;
                        end else begin
                            dead_cnt <= dead_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
